// File: rtl/regfile_pkg.sv
// Shared sizing and one-hot select constants for the register file.
package regfile_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int ADDR_W = $clog2(NREGS);

  localparam logic [7:0] SEL0 = 8'b0000_0001;
  localparam logic [7:0] SEL1 = 8'b0000_0010;
  localparam logic [7:0] SEL2 = 8'b0000_0100;
  localparam logic [7:0] SEL3 = 8'b0000_1000;
  localparam logic [7:0] SEL4 = 8'b0001_0000;
  localparam logic [7:0] SEL5 = 8'b0010_0000;
  localparam logic [7:0] SEL6 = 8'b0100_0000;
  localparam logic [7:0] SEL7 = 8'b1000_0000;

endpackage

// File: rtl/regfile_dec.sv
// Binary to one-hot decoder, n inputs to 2^n outputs.
module regfile_dec #(
  parameter int N = 3
) (
  input  logic [N-1:0]    bin_i,
  output logic [2**N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < 2**N; i++) begin
      onehot_o[i] = (bin_i == N'(i));
    end
  end

endmodule

// File: rtl/regfile.sv
// Eight-entry register file: one synchronous write port, one combinational
// one-hot AND-OR read port, asynchronous active-high clear.
module regfile #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int NREGS  = regfile_pkg::NREGS
) (
  input  logic [DATA_W-1:0]        data_in,
  input  logic [$clog2(NREGS)-1:0] writenum,
  input  logic                     write,
  input  logic [$clog2(NREGS)-1:0] readnum,
  input  logic                     clk,
  output logic [DATA_W-1:0]        data_out,
  input  logic                     reset
);

  import regfile_pkg::*;

  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0]  decOutWrite;
  logic [NREGS-1:0]  decOutRead;
  logic [NREGS-1:0]  load;
  logic [DATA_W-1:0] regs_q [NREGS];

  logic [DATA_W-1:0] R0, R1, R2, R3, R4, R5, R6, R7;

  regfile_dec #(.N(AW)) u_dec_write (
    .bin_i    (writenum),
    .onehot_o (decOutWrite)
  );

  regfile_dec #(.N(AW)) u_dec_read (
    .bin_i    (readnum),
    .onehot_o (decOutRead)
  );

  // An X/Z on write makes load unknown, which the if() below treats as no-load.
  always_comb begin
    load = '0;
    for (int n = 0; n < NREGS; n++) begin
      load[n] = write & decOutWrite[n];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NREGS; n++) regs_q[n] <= '0;
    end else begin
      for (int n = 0; n < NREGS; n++) begin
        if (load[n]) regs_q[n] <= data_in;
      end
    end
  end

  assign R0 = regs_q[0];
  assign R1 = regs_q[1];
  assign R2 = regs_q[2];
  assign R3 = regs_q[3];
  assign R4 = regs_q[4];
  assign R5 = regs_q[5];
  assign R6 = regs_q[6];
  assign R7 = regs_q[7];

  always_comb begin
    data_out = ({DATA_W{decOutRead[0]}} & R0)
             | ({DATA_W{decOutRead[1]}} & R1)
             | ({DATA_W{decOutRead[2]}} & R2)
             | ({DATA_W{decOutRead[3]}} & R3)
             | ({DATA_W{decOutRead[4]}} & R4)
             | ({DATA_W{decOutRead[5]}} & R5)
             | ({DATA_W{decOutRead[6]}} & R6)
             | ({DATA_W{decOutRead[7]}} & R7);
  end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile with hand-computed expectations.
module tb_regfile;

  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic        clk;
  logic [15:0] data_out;
  logic        reset;

  int n_cmp = 0;
  int n_err = 0;

  regfile dut (
    .data_in  (data_in),
    .writenum (writenum),
    .write    (write),
    .readnum  (readnum),
    .clk      (clk),
    .data_out (data_out),
    .reset    (reset)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] reg_val(input int n);
    case (n)
      0: return dut.R0;
      1: return dut.R1;
      2: return dut.R2;
      3: return dut.R3;
      4: return dut.R4;
      5: return dut.R5;
      6: return dut.R6;
      default: return dut.R7;
    endcase
  endfunction

  task automatic wr_chk(input int n, input logic [15:0] v);
    logic [7:0] sel;
    sel = 8'b0000_0001 << n;
    @(negedge clk);
    writenum = 3'(n);
    readnum  = 3'(n);
    data_in  = v;
    write    = 1'b1;
    #1;
    check($sformatf("decw%0d", n), 32'(dut.decOutWrite), 32'(sel));
    check($sformatf("decr%0d", n), 32'(dut.decOutRead), 32'(sel));
    @(posedge clk);
    #1;
    write = 1'b0;
    check($sformatf("R%0d", n), 32'(reg_val(n)), 32'(v));
    check($sformatf("dout%0d", n), 32'(data_out), 32'(v));
  endtask

  // Register contents expected after the load sequence.
  logic [15:0] exp_regs [8] = '{16'd0, 16'd14, 16'd23, 16'd42, 16'd20, 16'd32, 16'd11, 16'd20};

  initial begin
    reset    = 1'b1;
    write    = 1'b0;
    writenum = 3'd0;
    readnum  = 3'd0;
    data_in  = 16'd0;
    #2;
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_R0", 32'(dut.R0), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    wr_chk(3, 16'd42);
    wr_chk(1, 16'd14);
    wr_chk(2, 16'd23);
    wr_chk(4, 16'd20);
    wr_chk(5, 16'd32);
    wr_chk(6, 16'd11);
    wr_chk(7, 16'd20);

    for (int n = 0; n < 8; n++) check($sformatf("load_R%0d", n), 32'(reg_val(n)), 32'(exp_regs[n]));

    // write disabled: nothing changes
    @(negedge clk);
    write = 1'b0; writenum = 3'd7; readnum = 3'd7; data_in = 16'd15;
    @(posedge clk); #1;
    check("nowr_R7", 32'(dut.R7), 32'd20);
    check("nowr_dout", 32'(data_out), 32'd20);
    check("nowr_decw", 32'(dut.decOutWrite), 32'h80);

    // unknown write enable must not load
    @(negedge clk);
    write = 1'bx; writenum = 3'd6; readnum = 3'd6; data_in = 16'd77;
    @(posedge clk); #1;
    write = 1'b0;
    check("xwr_R6", 32'(dut.R6), 32'd11);

    // combinational read, no clock
    @(negedge clk);
    readnum = 3'd1; #1;
    check("rd1", 32'(data_out), 32'd14);
    readnum = 3'd3; #1;
    check("rd3", 32'(data_out), 32'd42);

    // same-index read/write: old before edge, new after
    @(negedge clk);
    writenum = 3'd2; readnum = 3'd2; data_in = 16'd99; write = 1'b1;
    #1;
    check("rw_before", 32'(data_out), 32'd23);
    @(posedge clk); #1;
    write = 1'b0;
    check("rw_after", 32'(data_out), 32'd99);

    // independent read and write in the same cycle
    @(negedge clk);
    writenum = 3'd6; readnum = 3'd4; data_in = 16'd5; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    check("indep_dout", 32'(data_out), 32'd20);
    check("indep_R6", 32'(dut.R6), 32'd5);

    // mid-cycle asynchronous reset, with a write attempted while held
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      readnum = 3'(n);
      #1;
      check($sformatf("arst_R%0d", n), 32'(reg_val(n)), 32'd0);
      check($sformatf("arst_dout%0d", n), 32'(data_out), 32'd0);
    end
    writenum = 3'd1; data_in = 16'd123; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
    check("rst_wr_ignored", 32'(dut.R1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    wr_chk(5, 16'd7);
    for (int n = 0; n < 8; n++)
      check($sformatf("post_R%0d", n), 32'(reg_val(n)), (n == 5) ? 32'd7 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
